ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: single-outstanding fetch FSM feeding a DEPTH-entry instruction FIFO
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        r_state;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_req_addr;
  logic [63:0]   r_wait_pc;
  logic          r_stale;
  logic [31:0]   r_data [DEPTH];
  logic [63:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic          w_space;
  logic [CW-1:0] w_count_nxt;
  logic [63:0]   w_redir_pc;

  assign w_redir_pc  = redirect_pc & ~64'h3;
  assign w_hs        = (r_state == S_REQ) && mem_req_ready;
  assign w_pop       = inst_valid && inst_ready;
  // A response racing a redirect belongs to the abandoned stream and is dropped.
  assign w_push      = (r_state == S_WAIT) && mem_resp_valid && !r_stale && !redirect_valid;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_space     = w_count_nxt < FULL;

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_req_addr;
  assign inst_valid    = (r_count != '0);
  assign inst          = r_data[r_rptr];
  assign inst_pc       = r_pc[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= mem_resp_data;
        r_pc[r_wptr]   <= r_wait_pc;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // r_req_addr holds the presented address; r_fetch_pc is the next address of the live stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_wait_pc  <= '0;
      r_stale    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_req_addr <= w_redir_pc;
            r_state    <= S_REQ;
          end else if (w_space) begin
            r_req_addr <= r_fetch_pc;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_hs) begin
            r_state   <= S_WAIT;
            r_wait_pc <= r_req_addr;
            if (redirect_valid) begin
              r_fetch_pc <= w_redir_pc;
              r_stale    <= 1'b1;
            end else if (!r_stale) begin
              r_fetch_pc <= r_fetch_pc + 64'd4;
            end
          end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_stale    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_stale <= 1'b0;
            if (redirect_valid) begin
              r_fetch_pc <= w_redir_pc;
              r_req_addr <= w_redir_pc;
              r_state    <= S_REQ;
            end else if (w_space) begin
              r_req_addr <= r_fetch_pc;
              r_state    <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_stale    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
